i2s_receiver: RTL and testbench

Serial-to-parallel I2S receiver, the stage directly downstream of `i2s_transmitter`. It samples `sd_rx` on rising `sclk` edges, frames the bits by `ws`, and presents one left/right sample pair per audio frame with a single-cycle valid strobe. Its inputs come from either the on-chip transmitter (loopback) or an external codec. Everything runs in the `mclk` domain.

---
 rtl/i2s_pkg.sv | 9 +
 rtl/i2s_input_sync.sv | 18 +
 rtl/i2s_receiver.sv | 107 ++++++++++
 tb/tb_i2s_receiver.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states and word-select polarity.
package i2s_pkg;

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} i2s_rx_state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_input_sync.sv
// Flip-flop chain that brings one asynchronous I2S line into the mclk domain.
module i2s_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel receiver: frames sd_rx by ws and strobes out one
// left/right pair per frame, all in the mclk domain.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ws,
    input  logic             sd_rx,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    output logic             rx_locked
);

    localparam int CW = $clog2(WIDTH + 1);

    logic w_sclk_s, w_ws_s, w_sd_s;
    logic r_sclk_d;
    logic w_rise, w_trans, w_has_room;
    logic w_load_left, w_emit;
    logic r_ws_prev;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift, r_left_hold, w_word;
    i2s_rx_state_t    r_state, w_state_next;

    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (.i_clk(mclk), .i_d(sclk),  .o_q(w_sclk_s));
    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws   (.i_clk(mclk), .i_d(ws),    .o_q(w_ws_s));
    i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd   (.i_clk(mclk), .i_d(sd_rx), .o_q(w_sd_s));

    // Left unreset so a reset taken while sclk is high cannot fake an edge.
    always_ff @(posedge mclk) begin
        r_sclk_d <= w_sclk_s;
    end

    assign w_rise     = w_sclk_s & ~r_sclk_d;
    assign w_trans    = w_ws_s != r_ws_prev;
    assign w_has_room = r_bit_cnt < CW'(WIDTH);

    // Bits land MSB-first at their final position, so short slots stay zero-filled.
    always_comb begin
        w_word = r_shift;
        if (w_has_room)
            w_word = r_shift | (WIDTH'(w_sd_s) << (CW'(WIDTH - 1) - r_bit_cnt));
    end

    always_ff @(posedge mclk) begin
        if (rst) r_state <= SYNC;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_left  = 1'b0;
        w_emit       = 1'b0;
        if (w_rise && w_trans) begin
            case (r_state)
                SYNC:  if (w_ws_s == WS_LEFT) w_state_next = LEFT;
                LEFT:  if (w_ws_s == WS_RIGHT) begin
                           w_state_next = RIGHT;
                           w_load_left  = 1'b1;
                       end
                RIGHT: if (w_ws_s == WS_LEFT) begin
                           w_state_next = LEFT;
                           w_emit       = 1'b1;
                       end
                default: w_state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_ws_prev   <= WS_RIGHT;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            rx_data_l   <= '0;
            rx_data_r   <= '0;
            rx_valid    <= 1'b0;
            rx_locked   <= 1'b0;
        end else begin
            rx_valid  <= w_emit;
            rx_locked <= w_state_next != SYNC;
            if (w_rise) begin
                r_ws_prev <= w_ws_s;
                if (w_trans) begin
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                end else if (w_has_room) begin
                    r_shift   <= w_word;
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
            if (w_load_left) r_left_hold <= w_word;
            if (w_emit) begin
                rx_data_l <= r_left_hold;
                rx_data_r <= w_word;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S frames and compares against a slot-level model.
module tb_i2s_receiver;

    localparam int WIDTH = 16;

    logic mclk = 1'b0;
    logic rst, sclk_i, ws_i, sd_i;
    logic [WIDTH-1:0] rx_data_l, rx_data_r;
    logic rx_valid, rx_locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic             m_prev, m_locked, pend, prev_v;
    logic [WIDTH-1:0] m_left, m_out_l, m_out_r;
    logic             m_bits[$];
    logic [WIDTH-1:0] eq_l[$], eq_r[$];
    int               eq_c[$];

    i2s_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .mclk(mclk), .rst(rst), .sclk(sclk_i), .ws(ws_i), .sd_rx(sd_i),
        .rx_data_l(rx_data_l), .rx_data_r(rx_data_r),
        .rx_valid(rx_valid), .rx_locked(rx_locked)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev   = 1'b1;
        m_locked = 1'b0;
        m_left   = '0;
        m_out_l  = '0;
        m_out_r  = '0;
        m_bits.delete();
        eq_l.delete(); eq_r.delete(); eq_c.delete();
    endtask

    // Slot model: a ws change closes the slot of the old ws value, with the bit
    // seen at that edge as its last bit; words keep the first WIDTH bits.
    task automatic model_step(input logic w, input logic d, input int c);
        logic [WIDTH-1:0] word;
        if (w != m_prev) begin
            m_bits.push_back(d);
            word = '0;
            for (int i = 0; i < m_bits.size() && i < WIDTH; i++)
                word[WIDTH-1-i] = m_bits[i];
            if (!m_locked) m_locked = (w == 1'b0);
            else if (w) m_left = word;
            else begin
                eq_l.push_back(m_left);
                eq_r.push_back(word);
                eq_c.push_back(c + 3);
            end
            m_bits.delete();
        end else begin
            m_bits.push_back(d);
        end
        m_prev = w;
    endtask

    // One sclk period (4 mclk low, 4 high); sd carries the bit queued by the previous call.
    task automatic ev(input logic w, input logic b);
        ws_i   = w;
        sd_i   = pend;
        sclk_i = 1'b0;
        repeat (4) @(negedge mclk);
        chk("rx_locked", rx_locked, m_locked);
        chk("hold_l", rx_data_l, m_out_l);
        chk("hold_r", rx_data_r, m_out_r);
        sclk_i = 1'b1;
        model_step(w, pend, cyc);
        pend = b;
        repeat (4) @(negedge mclk);
    endtask

    task automatic send_slot(input logic w, input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) ev(w, data[n-1-i]);
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_slot(1'b0, l, n);
        send_slot(1'b1, r, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge mclk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_locked", rx_locked, 0);
        chk("rst_l", rx_data_l, 0);
        chk("rst_r", rx_data_r, 0);
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge mclk) begin
        if (!rst && rx_valid) begin
            if (eq_l.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                chk("rx_data_l", rx_data_l, eq_l[0]);
                chk("rx_data_r", rx_data_r, eq_r[0]);
                chk("latency", cyc, eq_c[0]);
                m_out_l = eq_l.pop_front();
                m_out_r = eq_r.pop_front();
                void'(eq_c.pop_front());
            end
            chk("back_to_back", prev_v, 0);
        end
        prev_v = rx_valid;
    end

    initial begin
        int lens[6] = '{8, 12, 16, 17, 24, 32};
        logic [31:0] lw;
        model_reset();
        prev_v = 1'b0;
        rst = 1'b1; sclk_i = 1'b0; ws_i = 1'b1; sd_i = 1'b0; pend = 1'b0;
        repeat (3) @(negedge mclk);
        chk("init_valid", rx_valid, 0);
        chk("init_locked", rx_locked, 0);
        chk("init_l", rx_data_l, 0);
        chk("init_r", rx_data_r, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) ev(1'b1, 1'($urandom));
        frame(32'hA5C3, 32'h5A3C, 16);
        for (int f = 0; f < 4; f++) frame(32'hFFFF, 32'h1111, 16);
        for (int f = 0; f < 2; f++) frame({16'hBEEF, 16'($urandom)}, {16'h1234, 16'($urandom)}, 32);
        for (int f = 0; f < 2; f++) frame(32'hABC, 32'h123, 12);
        for (int f = 0; f < 6; f++) frame($urandom, $urandom, lens[$urandom_range(0, 5)]);

        lw = $urandom;
        for (int i = 0; i < 7; i++) ev(1'b0, lw[15-i]);
        do_reset();
        for (int i = 7; i < 16; i++) ev(1'b0, lw[15-i]);
        send_slot(1'b1, $urandom, 16);
        for (int f = 0; f < 3; f++) frame($urandom, $urandom, 16);
        send_slot(1'b0, $urandom, 16);

        repeat (10) @(negedge mclk);
        chk("pending_strobes", eq_l.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
